// File: rtl/split_line_fetch.sv
// Fetches one video line from MPMC memory in bursts and emits it horizontally shifted, with
// black fill outside the source span. Define SPLIT_LINE_EDGE_REPLICATE_EN for edge replication.
module split_line_fetch #(
  parameter int unsigned LINE_PIXELS = 1024,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [31:0]                    i_line_addr,
  input  logic [31:0]                    i_x_off,
  input  logic [31:0]                    i_dir,
  output logic                           o_rd_req,
  output logic [31:0]                    o_rd_addr,
  output logic [$clog2(BURST_LEN):0]     o_rd_len,
  input  logic                           i_rd_ack,
  input  logic [31:0]                    i_rd_data,
  input  logic                           i_rd_valid,
  output logic [31:0]                    o_pix_data,
  output logic                           o_pix_valid,
  input  logic                           i_pix_ready,
  output logic [$clog2(LINE_PIXELS)-1:0] o_pix_x,
  output logic                           o_busy,
  output logic                           o_line_done
);
  localparam int unsigned XW = $clog2(LINE_PIXELS);
  localparam int unsigned CW = XW + 1;
  localparam int unsigned LW = $clog2(BURST_LEN) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);  // FIFO_DEPTH is a power of two
  localparam int unsigned OW = AW + 1;
  localparam int unsigned SW = OW + 2;

  typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} state_e;

  state_e        r_state;
  logic [31:0]   r_line_addr, r_off;
  logic          r_dir, r_busy, r_line_done;
  logic [CW-1:0] r_x_lo, r_x_hi, r_src_next, r_req_left;
  logic [XW-1:0] r_x;
  logic [OW-1:0] r_inflight, r_occ;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]   r_mem [FIFO_DEPTH];

  logic          w_off_ok, w_run, w_in_range, w_peek, w_hold, w_use_fifo, w_fifo_empty;
  logic          w_rd_req, w_rd_fire, w_push, w_pop, w_pix_fire, w_space_ok;
  logic [CW-1:0] w_x_ext;
  logic [LW-1:0] w_burst_len;
  logic [31:0]   w_head, w_fill;

  assign w_off_ok     = r_off < 32'(LINE_PIXELS);
  assign w_run        = r_state == StRun;
  assign w_x_ext      = {1'b0, r_x};
  assign w_in_range   = (w_x_ext >= r_x_lo) && (w_x_ext < r_x_hi);
  assign w_fifo_empty = r_occ == '0;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_burst_len  = (r_req_left >= CW'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(r_req_left);
  // Reserve room for everything already requested so returning data can never overflow.
  assign w_space_ok   = (SW'(r_occ) + SW'(r_inflight) + SW'(w_burst_len)) <= SW'(FIFO_DEPTH);
  assign w_rd_req     = w_run && (r_req_left != '0) && w_space_ok;
  assign w_rd_fire    = w_rd_req && i_rd_ack;
  assign w_push       = i_rd_valid && (r_state != StIdle);

`ifdef SPLIT_LINE_EDGE_REPLICATE_EN
  logic [31:0] r_last;
  // r_x_hi is zero only when the offset is out of range, which keeps black fill.
  assign w_peek = r_dir && (w_x_ext < r_x_lo);
  assign w_hold = !r_dir && (r_x_hi != '0) && (w_x_ext >= r_x_hi);
  assign w_fill = w_hold ? r_last : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_last <= '0;
    else if (w_pop) r_last <= w_head;
  end
`else
  assign w_peek = 1'b0;
  assign w_hold = 1'b0;
  assign w_fill = '0;
`endif

  assign w_use_fifo  = w_in_range || w_peek;
  assign o_pix_valid = w_run && (!w_use_fifo || !w_fifo_empty);
  assign o_pix_data  = !o_pix_valid ? '0 : (w_use_fifo ? w_head : w_fill);
  assign o_pix_x     = r_x;
  assign w_pix_fire  = o_pix_valid && i_pix_ready;
  assign w_pop       = w_pix_fire && w_in_range;

  assign o_rd_req    = w_rd_req;
  assign o_rd_addr   = w_rd_req ? (r_line_addr + (32'(r_src_next) << 2)) : '0;
  assign o_rd_len    = w_rd_req ? w_burst_len : '0;
  assign o_busy      = r_busy;
  assign o_line_done = r_line_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_line_addr <= '0;
      r_off       <= '0;
      r_dir       <= 1'b0;
      r_x_lo      <= '0;
      r_x_hi      <= '0;
      r_src_next  <= '0;
      r_req_left  <= '0;
      r_x         <= '0;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_line_addr <= i_line_addr;
            r_off       <= i_x_off;
            r_dir       <= |i_dir;
            r_busy      <= 1'b1;
            r_state     <= StSetup;
          end
        end
        StSetup: begin
          r_x <= '0;
          if (w_off_ok) begin
            r_req_left <= CW'(LINE_PIXELS) - r_off[CW-1:0];
            r_src_next <= r_dir ? '0 : r_off[CW-1:0];
            r_x_lo     <= r_dir ? r_off[CW-1:0] : '0;
            r_x_hi     <= r_dir ? CW'(LINE_PIXELS) : CW'(LINE_PIXELS) - r_off[CW-1:0];
          end else begin
            r_req_left <= '0;
            r_src_next <= '0;
            r_x_lo     <= '0;
            r_x_hi     <= '0;
          end
          r_state <= StRun;
        end
        StRun: begin
          if (w_rd_fire) begin
            r_src_next <= r_src_next + CW'(w_burst_len);
            r_req_left <= r_req_left - CW'(w_burst_len);
          end
          if (w_pix_fire) begin
            r_x <= r_x + XW'(1);
            if (r_x == XW'(LINE_PIXELS - 1)) begin
              r_state     <= StDone;
              r_line_done <= 1'b1;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= '0;
      r_occ      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= r_inflight + (w_rd_fire ? OW'(w_burst_len) : OW'(0))
                               - (w_push ? OW'(1) : OW'(0));
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rd_data;
  end

endmodule

// File: tb/tb_split_line_fetch.sv
// Directed bench for split_line_fetch: memory responder model, per-line statistics and
// per-scenario checks with hand-computed expectations.
module tb_split_line_fetch;
  logic        clk, rst, start, rd_req, rd_ack, rd_valid, pix_valid, pix_ready, busy, line_done;
  logic [31:0] line_addr, x_off, dir, rd_addr, rd_data, pix_data;
  logic [4:0]  rd_len;
  logic [9:0]  pix_x;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] g_base, g_off, g_dir;
  logic [31:0] paddr[$];
  int          pdue[$];
  int          req_cnt, words_req, words_ret, px, mism, done_cnt, pre_fire, occ, max_occ;
  int          addr_err, busy_low, last_len, mm_x;
  logic [31:0] first_addr, exp_addr, mm_got, mm_exp;
  logic [9:0]  mm_gx;
  bit          seen_data, busy_after;

  split_line_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_line_addr(line_addr), .i_x_off(x_off),
    .i_dir(dir), .o_rd_req(rd_req), .o_rd_addr(rd_addr), .o_rd_len(rd_len), .i_rd_ack(rd_ack),
    .i_rd_data(rd_data), .i_rd_valid(rd_valid), .o_pix_data(pix_data),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_x(pix_x), .o_busy(busy),
    .o_line_done(line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC35A_0000;
  endfunction

  function automatic bit in_rng(input int x);
    if (g_off >= 1024) return 1'b0;
    if (g_dir == 0) return (32'(x) + g_off) < 1024;
    return 32'(x) >= g_off;
  endfunction

  function automatic logic [31:0] exp_pix(input int x);
    logic [31:0] xs;
    xs = 32'(x);
    if (in_rng(x)) return word_at(g_base + 4 * ((g_dir == 0) ? xs + g_off : xs - g_off));
`ifdef SPLIT_LINE_EDGE_REPLICATE_EN
    if (g_off < 1024) return (g_dir == 0) ? word_at(g_base + 32'd4092) : word_at(g_base);
`endif
    return 32'h0;
  endfunction

  // Runs one line: memory model with fixed latency, consumer, and statistics gathering.
  task automatic run_line(input logic [31:0] base, input logic [31:0] off, input logic [31:0] dr,
                          input int lat, input bit rnd, input int abort_px, input int bstart_px);
    bit done;
    bit bs;
    int tmp;
    done = 1'b0; bs = 1'b0;
    g_base = base; g_off = off; g_dir = dr;
    req_cnt = 0; words_req = 0; words_ret = 0; px = 0; mism = 0; done_cnt = 0; pre_fire = 0;
    occ = 0; max_occ = 0; addr_err = 0; busy_low = 0; last_len = 0; seen_data = 1'b0;
    first_addr = '0; busy_after = 1'b1;
    paddr.delete(); pdue.delete();
    exp_addr = base + ((off < 1024 && dr == 0) ? 4 * off : 32'd0);
    @(negedge clk);
    line_addr = base; x_off = off; dir = dr; start = 1'b1;
    for (int cyc = 0; cyc < 10000 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_px >= 0 && px >= abort_px) begin
        done = 1'b1;
      end else begin
        if (bstart_px >= 0 && !bs && px >= bstart_px) begin
          start = 1'b1; line_addr = ~base; x_off = 32'd0; dir = ~dr; bs = 1'b1;
        end
        if (line_done) begin done_cnt++; done = 1'b1; end
        if (!busy && !done) busy_low++;
        rd_ack = 1'b1;
        if (rd_req) begin
          if (req_cnt == 0) first_addr = rd_addr;
          if (rd_addr !== exp_addr) addr_err++;
          last_len = int'(rd_len);
          req_cnt++;
          words_req += int'(rd_len);
          for (int k = 0; k < int'(rd_len); k++) begin
            paddr.push_back(rd_addr + 32'(4 * k));
            pdue.push_back(cyc + lat);
          end
          exp_addr = exp_addr + 32'(4 * int'(rd_len));
        end
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_valid && pix_ready) begin
          if (pix_x !== 10'(px) || pix_data !== exp_pix(px)) begin
            if (mism == 0) begin mm_x = px; mm_gx = pix_x; mm_got = pix_data; mm_exp = exp_pix(px); end
            mism++;
          end
          if (!seen_data) pre_fire++;
          if (in_rng(px)) occ--;
          px++;
        end
        if (pdue.size() > 0 && pdue[0] <= cyc) begin
          rd_valid = 1'b1;
          rd_data = word_at(paddr.pop_front());
          tmp = pdue.pop_front();
          words_ret++; occ++; seen_data = 1'b1;
        end else begin
          rd_valid = 1'b0;
          rd_data = 32'hBAD0_BAD0;
        end
        if (occ > max_occ) max_occ = occ;
      end
    end
    if (abort_px < 0) begin
      rd_valid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (line_done) done_cnt++;
      end
      busy_after = busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; pix_ready = 1'b0;
    line_addr = '0; x_off = '0; dir = '0; rd_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({rd_req, pix_valid, busy, line_done} !== 4'b0)
      $display("FAIL reset_ctrl got %b want 0000", {rd_req, pix_valid, busy, line_done}); else n_pass++;
    n_checks++; if (rd_addr !== 32'h0 || rd_len !== 5'h0)
      $display("FAIL reset_rd got addr=%h len=%0d want 0/0", rd_addr, rd_len); else n_pass++;
    n_checks++; if (pix_x !== 10'h0 || pix_data !== 32'h0)
      $display("FAIL reset_pix got x=%0d data=%h want 0/0", pix_x, pix_data); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_no_shift;
    run_line(32'h3FFE_A000, 32'd0, 32'd0, 1, 1'b0, -1, -1);
    n_checks++; if (req_cnt !== 64) $display("FAIL off0_req_cnt got %0d want 64", req_cnt); else n_pass++;
    n_checks++; if (first_addr !== 32'h3FFE_A000)
      $display("FAIL off0_first_addr got %h want 3ffea000", first_addr); else n_pass++;
    n_checks++; if (last_len !== 16) $display("FAIL off0_last_len got %0d want 16", last_len); else n_pass++;
    n_checks++; if (addr_err !== 0) $display("FAIL off0_addr_seq got %0d bad want 0", addr_err); else n_pass++;
    n_checks++; if (px !== 1024) $display("FAIL off0_pix_count got %0d want 1024", px); else n_pass++;
    n_checks++; if (mism !== 0) $display("FAIL off0_pixels %0d bad, x=%0d got x=%0d %h want %h",
      mism, mm_x, mm_gx, mm_got, mm_exp); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL off0_line_done got %0d pulses want 1", done_cnt); else n_pass++;
    n_checks++; if (busy_low !== 0) $display("FAIL off0_busy_during got %0d low want 0", busy_low); else n_pass++;
    n_checks++; if (busy_after !== 1'b0) $display("FAIL off0_busy_after got %b want 0", busy_after); else n_pass++;
  endtask

  task automatic test_shift_left;
    run_line(32'h3FFE_A000, 32'd5, 32'd0, 1, 1'b0, -1, -1);
    n_checks++; if (first_addr !== 32'h3FFE_A014)
      $display("FAIL left_first_addr got %h want 3ffea014", first_addr); else n_pass++;
    n_checks++; if (last_len !== 11) $display("FAIL left_last_len got %0d want 11", last_len); else n_pass++;
    n_checks++; if (req_cnt !== 64) $display("FAIL left_req_cnt got %0d want 64", req_cnt); else n_pass++;
    n_checks++; if (words_req !== 1019) $display("FAIL left_words got %0d want 1019", words_req); else n_pass++;
    n_checks++; if (px !== 1024) $display("FAIL left_pix_count got %0d want 1024", px); else n_pass++;
    n_checks++; if (mism !== 0) $display("FAIL left_pixels %0d bad, x=%0d got x=%0d %h want %h",
      mism, mm_x, mm_gx, mm_got, mm_exp); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL left_line_done got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_shift_right;
    int want_pre;
`ifdef SPLIT_LINE_EDGE_REPLICATE_EN
    want_pre = 0;
`else
    want_pre = 3;
`endif
    run_line(32'h3FFE_A000, 32'd3, 32'd1, 20, 1'b0, -1, -1);
    n_checks++; if (first_addr !== 32'h3FFE_A000)
      $display("FAIL right_first_addr got %h want 3ffea000", first_addr); else n_pass++;
    n_checks++; if (last_len !== 13) $display("FAIL right_last_len got %0d want 13", last_len); else n_pass++;
    n_checks++; if (words_req !== 1021) $display("FAIL right_words got %0d want 1021", words_req); else n_pass++;
    n_checks++; if (pre_fire !== want_pre)
      $display("FAIL right_lead_before_data got %0d want %0d", pre_fire, want_pre); else n_pass++;
    n_checks++; if (mism !== 0) $display("FAIL right_pixels %0d bad, x=%0d got x=%0d %h want %h",
      mism, mm_x, mm_gx, mm_got, mm_exp); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL right_line_done got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_out_of_range;
    for (int d = 0; d < 2; d++) begin
      run_line(32'h3FFE_A000, 32'd2000, 32'(d), 1, 1'b0, -1, -1);
      n_checks++; if (req_cnt !== 0) $display("FAIL oor%0d_req_cnt got %0d want 0", d, req_cnt); else n_pass++;
      n_checks++; if (px !== 1024) $display("FAIL oor%0d_pix_count got %0d want 1024", d, px); else n_pass++;
      n_checks++; if (mism !== 0) $display("FAIL oor%0d_pixels %0d bad, x=%0d got %h want %h",
        d, mism, mm_x, mm_got, mm_exp); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL oor%0d_line_done got %0d want 1", d, done_cnt); else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    run_line(32'hFFFF_F800, 32'd7, 32'd1, 20, 1'b1, -1, 300);
    n_checks++; if (max_occ > 32) $display("FAIL bp_fifo_occupancy got %0d want <=32", max_occ); else n_pass++;
    n_checks++; if (words_req !== 1017) $display("FAIL bp_words_req got %0d want 1017", words_req); else n_pass++;
    n_checks++; if (words_ret !== 1017) $display("FAIL bp_words_ret got %0d want 1017", words_ret); else n_pass++;
    n_checks++; if (addr_err !== 0) $display("FAIL bp_addr_seq got %0d bad want 0", addr_err); else n_pass++;
    n_checks++; if (px !== 1024) $display("FAIL bp_pix_count got %0d want 1024", px); else n_pass++;
    n_checks++; if (mism !== 0) $display("FAIL bp_pixels %0d bad, x=%0d got x=%0d %h want %h",
      mism, mm_x, mm_gx, mm_got, mm_exp); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL bp_line_done got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_line;
    run_line(32'h1000_0000, 32'd9, 32'd0, 4, 1'b0, 500, 100);
    n_checks++; if (mism !== 0 || px !== 500) $display("FAIL rst_pre_pixels got %0d px %0d bad want 500/0",
      px, mism); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL rst_pre_done got %0d want 0", done_cnt); else n_pass++;
    rst = 1'b1; start = 1'b1; rd_valid = 1'b0; line_addr = 32'h2222_0000;
    @(negedge clk);
    n_checks++; if ({rd_req, pix_valid, busy, line_done} !== 4'b0)
      $display("FAIL rst_mid_ctrl got %b want 0000", {rd_req, pix_valid, busy, line_done}); else n_pass++;
    n_checks++; if (rd_addr !== 32'h0 || rd_len !== 5'h0)
      $display("FAIL rst_mid_rd got addr=%h len=%0d want 0/0", rd_addr, rd_len); else n_pass++;
    n_checks++; if (pix_x !== 10'h0 || pix_data !== 32'h0)
      $display("FAIL rst_mid_pix got x=%0d data=%h want 0/0", pix_x, pix_data); else n_pass++;
    rst = 1'b0; start = 1'b0;
    rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rd_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got %b want 0", busy); else n_pass++;
    run_line(32'h2000_0400, 32'd9, 32'd0, 4, 1'b0, -1, -1);
    n_checks++; if (first_addr !== 32'h2000_0424)
      $display("FAIL rst_new_first_addr got %h want 20000424", first_addr); else n_pass++;
    n_checks++; if (words_req !== 1015) $display("FAIL rst_new_words got %0d want 1015", words_req); else n_pass++;
    n_checks++; if (px !== 1024) $display("FAIL rst_new_pix_count got %0d want 1024", px); else n_pass++;
    n_checks++; if (mism !== 0) $display("FAIL rst_new_pixels %0d bad, x=%0d got x=%0d %h want %h",
      mism, mm_x, mm_gx, mm_got, mm_exp); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL rst_new_line_done got %0d want 1", done_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_shift();
    test_shift_left();
    test_shift_right();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/split_line_fetch.md
Name: split_line_fetch

Overview:
Downstream of the vertical address generator in the split_compensate pipeline. Takes one line's byte base address plus a horizontal offset/direction. Issues burst reads of that line from MPMC video memory, 32-bit pixels, byte addressed, and emits a horizontally shifted pixel stream of exactly LINE_PIXELS pixels. Out-of-range pixels are filled black. One line per i_start; the line counter upstream advances on o_line_done.

Parameters:
LINE_PIXELS, 1024, pixels per line (power of two)
BURST_LEN, 16, maximum words per read request
FIFO_DEPTH, 32, pixel FIFO entries; must be >= 2*BURST_LEN

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; latch inputs and begin a line (ignored unless IDLE)
i_line_addr  in  32  byte address of source line pixel 0
i_x_off  in  32  horizontal offset in pixels
i_dir  in  32  0: src = x + off (shift left); nonzero: src = x - off (shift right)
o_rd_req  out  1  read request valid
o_rd_addr  out  32  byte address of first word of burst
o_rd_len  out  clog2(BURST_LEN)+1  words in burst (1..BURST_LEN)
i_rd_ack  in  1  request accepted this cycle (req && ack)
i_rd_data  in  32  read data word
i_rd_valid  in  1  read data valid, in address order, no backpressure
o_pix_data  out  32  output pixel
o_pix_valid  out  1  pixel valid
i_pix_ready  in  1  consumer accepts pixel (valid && ready)
o_pix_x  out  log2(LINE_PIXELS)  destination column of o_pix_data
o_busy  out  1  high from start accepted until line done
o_line_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0, in-flight count 0.
- FSM: IDLE -> SETUP (on i_start) -> RUN -> DONE -> IDLE. o_busy is high in SETUP/RUN/DONE. o_line_done is high only in DONE, for one cycle.
- SETUP (1 cycle) computes src_first and src_count, the in-range source span:
  - dir=0: src_first = off, src_count = LINE_PIXELS - off.
  - dir!=0: src_first = 0, src_count = LINE_PIXELS - off.
  - off >= LINE_PIXELS: src_count = 0, no reads.
  - Destination x range that maps in range: dir=0 -> [0, src_count-1]; dir!=0 -> [off, LINE_PIXELS-1].
- Fetch side (RUN), concurrent with emit:
  - Assert o_rd_req while words remain to request AND (FIFO occupancy + words in flight + next burst length) <= FIFO_DEPTH.
  - o_rd_addr = i_line_addr + 4*src_next.
  - o_rd_len = min(BURST_LEN, remaining).
  - Hold req/addr/len stable until i_rd_ack. On ack, advance src_next and add len to in-flight.
  - Each i_rd_valid pushes a word and decrements in-flight. i_rd_valid in IDLE is ignored and discarded.
- Emit side (RUN), x from 0 to LINE_PIXELS-1:
  - If x maps in range, the pixel is the FIFO head. o_pix_valid is low while the FIFO is empty. Pop on accept.
  - Otherwise o_pix_data = 0 with o_pix_valid = 1.
  - o_pix_valid/data/x are held stable until i_pix_ready. Advance x on accept. Throughput is 1 pixel/cycle when data is available.
- RUN -> DONE when the pixel at x = LINE_PIXELS-1 is accepted. All requested words have been consumed by then.
- Simultaneous FIFO push and pop in the same cycle: occupancy unchanged.
- i_start while busy: ignored, latched inputs unchanged.
- i_rst mid-line: immediate return to IDLE, FIFO flushed, in-flight cleared, no o_line_done. The memory side must not return data after reset.
- Arithmetic: compute the offset compare in 32 bits. Addresses wrap modulo 2^32.

Optional Feature:
SPLIT_LINE_EDGE_REPLICATE_EN
- Defined: out-of-range pixels replicate the nearest edge pixel instead of black.
  - dir!=0 leading pixels output the FIFO head without popping; o_pix_valid is low until it is present.
  - dir=0 trailing pixels repeat the last popped pixel, held in a register.
  - off >= LINE_PIXELS still outputs black.
- Undefined: black fill. No extra register, no peek path.

Test Plan:
- off=0, dir=0, addr=0x3FFEA000, ack and ready always 1 -> 64 requests of len 16, addresses 0x3FFEA000 + 64*k. Output equals source, 1024 pixels. o_line_done pulses once.
- off=5, dir=0 -> first rd_addr 0x3FFEA014, last request len 11. x=0..1018 carry src 5..1023. x=1019..1023 = 0.
- off=3, dir=1 -> first rd_addr = line base. x=0..2 = 0 with valid high before any read data. x=3 carries src 0. Last request len 13.
- off=2000, either dir -> no o_rd_req ever. 1024 zero pixels, then o_line_done.
- Random i_pix_ready (50%), rd_data latency 20 cycles -> FIFO never exceeds FIFO_DEPTH. Data and ordering are correct, with no drops or duplicates.
- i_rst asserted at x=500 then i_start re-issued -> outputs 0 on the reset cycle. The new line completes correctly with no stale pixels. i_start while busy has no effect.
